// File: rtl/core_seq_if.sv
// -----------------------------------------------------------------------------
// core_seq_if -- memory handshake bundle between the core sequencer and the
// instruction/data memories.
//
// Signals (directions as seen from the sequencer, i.e. the master side):
//   imem_req_o    out  instruction fetch request
//   imem_ready_i  in   instruction word valid for the current PC
//   ir_en_o       out  instruction register load strobe
//   dmem_req_o    out  data access request
//   dmem_we_o     out  data access is a write
//   dmem_ready_i  in   data access complete
//
// The signal names keep the core-relative _i/_o suffixes, so the memory
// (slave) side drives the *_i signals and observes the *_o signals.
// -----------------------------------------------------------------------------
interface core_seq_if;
    logic imem_req_o;
    logic imem_ready_i;
    logic ir_en_o;
    logic dmem_req_o;
    logic dmem_we_o;
    logic dmem_ready_i;

    modport master (
        output imem_req_o, ir_en_o, dmem_req_o, dmem_we_o,
        input  imem_ready_i, dmem_ready_i
    );

    modport slave (
        input  imem_req_o, ir_en_o, dmem_req_o, dmem_we_o,
        output imem_ready_i, dmem_ready_i
    );
endinterface

// File: rtl/core_seq.sv
// -----------------------------------------------------------------------------
// core_seq -- multi-cycle instruction sequencer for a simple 32-bit core.
//
// Walks each instruction through FETCH -> DECODE -> EXECUTE -> (MEM) ->
// WRITEBACK, producing the memory, instruction-register, register-file and
// retire strobes, and owns the program counter. Illegal instructions and
// misaligned taken targets park the block in a sticky TRAP state; a level
// halt request parks it in HALT after the current instruction retires.
//
// Parameters:
//   RESET_PC       PC value loaded while reset is asserted
//
// Ports:
//   clk_i          clock, all state updates on the rising edge
//   rstn_i         asynchronous active-low reset
//   mem_if         memory handshake bundle (core_seq_if.master)
//   dec_*_i        decode flags, sampled in DECODE
//   br_taken_i     branch condition, sampled in EXECUTE
//   target_i       branch/jump target, sampled in EXECUTE
//   halt_req_i     level request to stop after the current instruction
//   pc_o           current PC
//   rf_wr_en_o     register file write enable
//   retire_o       instruction retired this cycle
//   state_o        FSM state code
//   halted_o       in HALT
//   trap_o         in TRAP
//   cycle_cnt_o    (CORE_SEQ_PERF_EN only) cycles since reset release
//   instret_o      (CORE_SEQ_PERF_EN only) retired instruction count
//
// Build option: define CORE_SEQ_PERF_EN to add the performance counters.
// -----------------------------------------------------------------------------
module core_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    core_seq_if.master        mem_if,
    input  logic              dec_wr_en_i,
    input  logic              dec_load_i,
    input  logic              dec_store_i,
    input  logic              dec_branch_i,
    input  logic              dec_jump_i,
    input  logic              dec_illegal_i,
    input  logic              br_taken_i,
    input  logic [31:0]       target_i,
    input  logic              halt_req_i,
    output logic [31:0]       pc_o,
    output logic              rf_wr_en_o,
    output logic              retire_o,
    output logic [2:0]        state_o,
    output logic              halted_o,
    output logic              trap_o
`ifdef CORE_SEQ_PERF_EN
    ,
    output logic [31:0]       cycle_cnt_o,
    output logic [31:0]       instret_o
`endif
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5,
        S_TRAP      = 3'd6
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg;
    logic [31:0] next_pc_reg;
    logic        wr_en_reg, load_reg, store_reg, branch_reg, jump_reg;

    // Redirect decision, only meaningful while in EXECUTE.
    logic        taken;
    logic [31:0] exec_next_pc;
    logic        misaligned;

    assign taken        = jump_reg | (branch_reg & br_taken_i);
    assign exec_next_pc = taken ? target_i : pc_reg + 32'd4;
    assign misaligned   = taken & (target_i[1:0] != 2'b00);

    // ---------------- state register ----------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pc_reg      <= RESET_PC;
            next_pc_reg <= RESET_PC;
            wr_en_reg   <= 1'b0;
            load_reg    <= 1'b0;
            store_reg   <= 1'b0;
            branch_reg  <= 1'b0;
            jump_reg    <= 1'b0;
        end else begin
            if (state_reg == S_DECODE) begin
                wr_en_reg  <= dec_wr_en_i;
                load_reg   <= dec_load_i;
                store_reg  <= dec_store_i;
                branch_reg <= dec_branch_i;
                jump_reg   <= dec_jump_i;
            end
            // A misaligned target also lands here, but the PC is only
            // committed in WRITEBACK, which a trapping instruction never reaches.
            if (state_reg == S_EXECUTE) begin
                next_pc_reg <= exec_next_pc;
            end
            if (state_reg == S_WRITEBACK) begin
                pc_reg <= next_pc_reg;
            end
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:     state_next = mem_if.imem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE:    state_next = dec_illegal_i ? S_TRAP : S_EXECUTE;
            S_EXECUTE: begin
                if (misaligned) begin
                    state_next = S_TRAP;
                end else if (load_reg | store_reg) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WRITEBACK;
                end
            end
            S_MEM:       state_next = mem_if.dmem_ready_i ? S_WRITEBACK : S_MEM;
            S_WRITEBACK: state_next = halt_req_i ? S_HALT : S_FETCH;
            S_HALT:      state_next = halt_req_i ? S_HALT : S_FETCH;
            S_TRAP:      state_next = S_TRAP;
            default:     state_next = S_TRAP;   // unused code 7
        endcase
    end

    // ---------------- output logic ----------------
    // Strobes are gated with rstn_i so they drop the instant reset asserts,
    // even though the state register then reads FETCH.
    always_comb begin
        mem_if.imem_req_o = 1'b0;
        mem_if.ir_en_o    = 1'b0;
        mem_if.dmem_req_o = 1'b0;
        mem_if.dmem_we_o  = 1'b0;
        rf_wr_en_o        = 1'b0;
        retire_o          = 1'b0;
        if (rstn_i) begin
            case (state_reg)
                S_FETCH: begin
                    mem_if.imem_req_o = 1'b1;
                    mem_if.ir_en_o    = mem_if.imem_ready_i;
                end
                S_MEM: begin
                    mem_if.dmem_req_o = 1'b1;
                    mem_if.dmem_we_o  = store_reg;
                end
                S_WRITEBACK: begin
                    rf_wr_en_o = wr_en_reg & ~store_reg;
                    retire_o   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign pc_o     = pc_reg;
    assign state_o  = state_reg;
    assign halted_o = (state_reg == S_HALT);
    assign trap_o   = (state_reg == S_TRAP);

`ifdef CORE_SEQ_PERF_EN
    logic [31:0] cycle_cnt_reg;
    logic [31:0] instret_reg;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cycle_cnt_reg <= 32'd0;
            instret_reg   <= 32'd0;
        end else begin
            cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
            if (state_reg == S_WRITEBACK) begin
                instret_reg <= instret_reg + 32'd1;
            end
        end
    end

    assign cycle_cnt_o = cycle_cnt_reg;
    assign instret_o   = instret_reg;
`endif

endmodule

// File: tb/tb_core_seq.sv
// -----------------------------------------------------------------------------
// tb_core_seq -- self-checking bench for core_seq.
//
// Each instruction is described by its decode flags and memory wait counts;
// the bench expands that into the expected phase list (fetch cycles, decode,
// execute, data cycles, writeback), drives the memory ready signals from that
// schedule, scrambles every input that the current phase should ignore, and
// compares state, strobes, status and PC every cycle. The PC model is plain
// arithmetic on the instruction's redirect rules.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_core_seq;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int PH_F = 0, PH_D = 1, PH_E = 2, PH_M = 3, PH_W = 4;
    localparam int ST_HALT = 5, ST_TRAP = 6;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        dec_wr_en_i, dec_load_i, dec_store_i, dec_branch_i, dec_jump_i, dec_illegal_i;
    logic        br_taken_i;
    logic [31:0] target_i;
    logic        halt_req_i;
    logic [31:0] pc_o;
    logic        rf_wr_en_o, retire_o, halted_o, trap_o;
    logic [2:0]  state_o;
`ifdef CORE_SEQ_PERF_EN
    logic [31:0] cycle_cnt_o, instret_o;
`endif

    core_seq_if mem_if ();

    core_seq #(.RESET_PC(RST_PC)) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .mem_if        (mem_if),
        .dec_wr_en_i   (dec_wr_en_i),
        .dec_load_i    (dec_load_i),
        .dec_store_i   (dec_store_i),
        .dec_branch_i  (dec_branch_i),
        .dec_jump_i    (dec_jump_i),
        .dec_illegal_i (dec_illegal_i),
        .br_taken_i    (br_taken_i),
        .target_i      (target_i),
        .halt_req_i    (halt_req_i),
        .pc_o          (pc_o),
        .rf_wr_en_o    (rf_wr_en_o),
        .retire_o      (retire_o),
        .state_o       (state_o),
        .halted_o      (halted_o),
        .trap_o        (trap_o)
`ifdef CORE_SEQ_PERF_EN
        ,
        .cycle_cnt_o   (cycle_cnt_o),
        .instret_o     (instret_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] pc_m;
    int unsigned cyc_m, ret_m;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end of test, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Random values on every input; callers then overwrite what matters.
    task automatic scramble();
        mem_if.imem_ready_i = 1'($urandom);
        mem_if.dmem_ready_i = 1'($urandom);
        dec_wr_en_i   = 1'($urandom);
        dec_load_i    = 1'($urandom);
        dec_store_i   = 1'($urandom);
        dec_branch_i  = 1'($urandom);
        dec_jump_i    = 1'($urandom);
        dec_illegal_i = 1'($urandom);
        br_taken_i    = 1'($urandom);
        target_i      = $urandom;
        halt_req_i    = 1'($urandom);
    endtask

    // es = {imem_req, ir_en, dmem_req, dmem_we, rf_wr_en, retire}
    task automatic check_cycle(input int es_state, input logic [5:0] es, input logic [31:0] epc);
        chk("state", {29'd0, state_o}, es_state);
        chk("strobes", {26'd0, mem_if.imem_req_o, mem_if.ir_en_o, mem_if.dmem_req_o,
                        mem_if.dmem_we_o, rf_wr_en_o, retire_o}, {26'd0, es});
        chk("halted", {31'd0, halted_o}, (es_state == ST_HALT) ? 32'd1 : 32'd0);
        chk("trap", {31'd0, trap_o}, (es_state == ST_TRAP) ? 32'd1 : 32'd0);
        chk("pc", pc_o, epc);
`ifdef CORE_SEQ_PERF_EN
        chk("cycle_cnt", cycle_cnt_o, cyc_m);
        chk("instret", instret_o, ret_m);
`endif
    endtask

    // Assert reset a few ns into the current cycle, check outputs at once,
    // release on a falling edge so the next cycle is the first one out of reset.
    task automatic do_reset();
        #2;
        scramble();
        rstn_i = 1'b0;
        #1;
        cyc_m = 0;
        ret_m = 0;
        pc_m  = RST_PC;
        check_cycle(PH_F, 6'b000000, RST_PC);
        @(negedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
    endtask

    task automatic run_instr(input logic wr, ld, st, br, jp, ill, bt,
                             input logic [31:0] tgt, input int fw, dw,
                             input logic hreq, input int abort_at);
        int          ph[$];
        logic        taken;
        logic [31:0] nxt;
        logic [5:0]  es;
        bit          trapped;
        taken   = jp | (br & bt);
        nxt     = taken ? tgt : pc_m + 32'd4;
        trapped = 1'b0;
        for (int i = 0; i <= fw; i++) ph.push_back(PH_F);
        ph.push_back(PH_D);
        if (ill) begin
            trapped = 1'b1;
        end else begin
            ph.push_back(PH_E);
            if (taken && tgt[1:0] != 2'b00) begin
                trapped = 1'b1;
            end else begin
                if (ld | st) for (int i = 0; i <= dw; i++) ph.push_back(PH_M);
                ph.push_back(PH_W);
            end
        end
        for (int k = 0; k < ph.size(); k++) begin
            scramble();
            es = 6'b000000;
            case (ph[k])
                PH_F: begin
                    mem_if.imem_ready_i = (k == fw);
                    es = {1'b1, (k == fw), 4'b0000};
                end
                PH_D: begin
                    dec_wr_en_i = wr; dec_load_i = ld; dec_store_i = st;
                    dec_branch_i = br; dec_jump_i = jp; dec_illegal_i = ill;
                end
                PH_E: begin
                    br_taken_i = bt;
                    target_i   = tgt;
                end
                PH_M: begin
                    mem_if.dmem_ready_i = (k == fw + 3 + dw);
                    es = {2'b00, 1'b1, st, 2'b00};
                end
                PH_W: begin
                    halt_req_i = hreq;
                    es = {4'b0000, wr & ~st, 1'b1};
                end
                default: ;
            endcase
            #1;
            check_cycle(ph[k], es, pc_m);
            if (k == abort_at) begin
                do_reset();
                return;
            end
            @(negedge clk_i);
            cyc_m++;
            if (ph[k] == PH_W) ret_m++;
        end
        if (!trapped) pc_m = nxt;
    endtask

    task automatic hold_trap(input int n);
        for (int i = 0; i < n; i++) begin
            scramble();
            #1;
            check_cycle(ST_TRAP, 6'b000000, pc_m);
            @(negedge clk_i);
            cyc_m++;
        end
    endtask

    // n cycles with the request held, then one cycle with it dropped; the
    // block is still in HALT that cycle and in FETCH the next.
    task automatic do_halt(input int n);
        for (int i = 0; i < n; i++) begin
            scramble();
            halt_req_i = 1'b1;
            #1;
            check_cycle(ST_HALT, 6'b000000, pc_m);
            @(negedge clk_i);
            cyc_m++;
        end
        scramble();
        halt_req_i = 1'b0;
        #1;
        check_cycle(ST_HALT, 6'b000000, pc_m);
        @(negedge clk_i);
        cyc_m++;
    endtask

    initial begin
        int          kind, fw, dw;
        logic        wr, bt, h;
        logic [31:0] t;

        scramble();
        rstn_i = 1'b1;
        pc_m   = RST_PC;
        cyc_m  = 0;
        ret_m  = 0;
        @(negedge clk_i);
        do_reset();

        // ALU ops with ready memories: 4-cycle cadence, PC steps by 4.
        repeat (3) run_instr(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, -1);
        // Load with three data wait cycles.
        run_instr(1, 1, 0, 0, 0, 0, 0, 32'h0, 0, 3, 0, -1);
        // Taken branch to 0x200.
        run_instr(0, 0, 0, 1, 0, 0, 1, 32'h0000_0200, 0, 0, 0, -1);
        #1;
        chk("branch_pc", pc_o, 32'h0000_0200);
        // Halt after retire, resume at the next PC.
        run_instr(1, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 1, -1);
        do_halt(3);

        repeat (60) begin
            kind = $urandom_range(0, 4);
            fw   = $urandom_range(0, 3);
            dw   = $urandom_range(0, 3);
            wr   = 1'($urandom);
            bt   = 1'($urandom);
            h    = ($urandom_range(0, 7) == 0);
            t    = $urandom & 32'hFFFF_FFFC;
            run_instr(wr, kind == 1, kind == 2, kind == 3, kind == 4, 1'b0, bt, t, fw, dw, h, -1);
            if (h) do_halt($urandom_range(0, 3));
        end

        // Store at the top of the address space wraps the PC to zero.
        run_instr(0, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFFC, 0, 0, 0, -1);
        run_instr(1, 0, 1, 0, 0, 0, 0, 32'h0, 0, 1, 0, -1);
        #1;
        chk("pc_wrap", pc_o, 32'h0000_0000);

        // Reset in the middle of a data access, then mid-fetch.
        run_instr(1, 1, 0, 0, 0, 0, 0, 32'h0, 0, 2, 0, 4);
        run_instr(1, 0, 0, 0, 0, 0, 0, 32'h0, 3, 0, 0, 1);
        run_instr(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, -1);

        // Illegal instruction traps with the PC of the faulting instruction.
        run_instr(1, 0, 0, 0, 0, 1, 0, 32'h0, 1, 0, 0, -1);
        hold_trap(5);
        do_reset();

        // Misaligned taken target traps and stays trapped.
        run_instr(0, 0, 0, 1, 0, 0, 1, 32'h0000_0202, 0, 0, 0, -1);
        hold_trap(100);
        do_reset();
        run_instr(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
